// File: rtl/step_fsm_monitor_tmr.sv
// ---------------------------------------------------------------------------
// step_fsm_monitor_tmr
//
// Triplicated monitor for the TMR step FSM. It votes the three state copies,
// detects entries into S1_C, S2_C and ERROR, and counts each one in a
// saturating counter. It also queues every detected entry as an event code in
// a 2-deep buffer that is drained through a valid/ready handshake. All state
// is held in three copies. Each copy reloads from the voted value, so a
// single upset copy is corrected on the next clock.
//
// Optional feature (macro STEP_FSM_MON_MISMATCH_EN): adds mismatch_o, a
// sticky flag that is set when the three input copies disagree.
//
// Ports:
//   clk_i                   single clock
//   rst_i                   synchronous, active-high reset
//   state_a_i/b_i/c_i       three state copies from the step FSM
//   clear_i                 synchronous clear of all counters (and mismatch)
//   s1_cnt_o                voted count of S1 completions
//   s2_cnt_o                voted count of S2 completions
//   err_cnt_o               voted count of ERROR entries
//   drop_cnt_o              voted count of events lost to a full buffer
//   evt_valid_o             event buffer head valid
//   evt_code_o              head event: 01 S1 done, 10 S2 done, 11 error
//   evt_ready_i             consumer accepts head when high with evt_valid_o
//   mismatch_o              sticky copy-disagreement flag (macro only)
// ---------------------------------------------------------------------------
module step_fsm_monitor_tmr #(
  parameter int                   IO_SIZE_G     = 3,
  parameter logic [IO_SIZE_G-1:0] IDLE          = IO_SIZE_G'(0),
  parameter logic [IO_SIZE_G-1:0] S1_C          = IO_SIZE_G'(3),
  parameter logic [IO_SIZE_G-1:0] S2_C          = IO_SIZE_G'(6),
  parameter logic [IO_SIZE_G-1:0] ERROR         = IO_SIZE_G'(7),
  parameter logic [IO_SIZE_G-1:0] RESET_STATE_G = IDLE,
  parameter int                   CNT_W_G       = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IO_SIZE_G-1:0] state_a_i,
  input  logic [IO_SIZE_G-1:0] state_b_i,
  input  logic [IO_SIZE_G-1:0] state_c_i,
  input  logic                 clear_i,
  output logic [CNT_W_G-1:0]   s1_cnt_o,
  output logic [CNT_W_G-1:0]   s2_cnt_o,
  output logic [CNT_W_G-1:0]   err_cnt_o,
  output logic [CNT_W_G-1:0]   drop_cnt_o,
  output logic                 evt_valid_o,
  output logic [1:0]           evt_code_o,
  input  logic                 evt_ready_i
`ifdef STEP_FSM_MON_MISMATCH_EN
  ,
  output logic                 mismatch_o
`endif
);

  localparam logic [CNT_W_G-1:0] CNT_MAX = '1;
  localparam logic [1:0] CODE_S1  = 2'b01;
  localparam logic [1:0] CODE_S2  = 2'b10;
  localparam logic [1:0] CODE_ERR = 2'b11;

  // Counter index: 0 = S1, 1 = S2, 2 = ERROR, 3 = drop
  localparam int N_CNT = 4;

  logic [IO_SIZE_G-1:0] voted_state;
  logic [IO_SIZE_G-1:0] prev_state;
  logic [IO_SIZE_G-1:0] prev_copy [3];

  logic [CNT_W_G-1:0]   cnt_copy  [3][N_CNT];
  logic [CNT_W_G-1:0]   cnt_voted [N_CNT];
  logic [N_CNT-1:0]     cnt_inc;

  logic [1:0] buf_cnt_copy  [3];
  logic [1:0] buf_head_copy [3];
  logic [1:0] buf_tail_copy [3];
  logic [1:0] buf_cnt, buf_head, buf_tail;
  logic [1:0] buf_cnt_next, buf_head_next, buf_tail_next;
  logic [1:0] buf_slot;

  logic       evt_fire;
  logic [1:0] evt_code;
  logic       evt_pop;
  logic       evt_push;
  logic       evt_drop;

  // Bitwise majority of the incoming copies
  assign voted_state = (state_a_i & state_b_i) | (state_a_i & state_c_i) |
                       (state_b_i & state_c_i);

  assign prev_state = (prev_copy[0] & prev_copy[1]) | (prev_copy[0] & prev_copy[2]) |
                      (prev_copy[1] & prev_copy[2]);

  assign buf_cnt  = (buf_cnt_copy[0] & buf_cnt_copy[1]) | (buf_cnt_copy[0] & buf_cnt_copy[2]) |
                    (buf_cnt_copy[1] & buf_cnt_copy[2]);
  assign buf_head = (buf_head_copy[0] & buf_head_copy[1]) | (buf_head_copy[0] & buf_head_copy[2]) |
                    (buf_head_copy[1] & buf_head_copy[2]);
  assign buf_tail = (buf_tail_copy[0] & buf_tail_copy[1]) | (buf_tail_copy[0] & buf_tail_copy[2]) |
                    (buf_tail_copy[1] & buf_tail_copy[2]);

  // Entry detection: a state only counts on the cycle it is first seen
  always_comb begin
    evt_fire = 1'b0;
    evt_code = 2'b00;
    if (voted_state != prev_state) begin
      if (voted_state == S1_C) begin
        evt_fire = 1'b1;
        evt_code = CODE_S1;
      end else if (voted_state == S2_C) begin
        evt_fire = 1'b1;
        evt_code = CODE_S2;
      end else if (voted_state == ERROR) begin
        evt_fire = 1'b1;
        evt_code = CODE_ERR;
      end
    end
  end

  assign evt_valid_o = (buf_cnt != 2'd0);
  assign evt_code_o  = evt_valid_o ? buf_head : 2'b00;

  // A full buffer still accepts a new event when its head leaves this cycle
  assign evt_pop  = evt_valid_o && evt_ready_i;
  assign evt_push = evt_fire && ((buf_cnt != 2'd2) || evt_pop);
  assign evt_drop = evt_fire && !evt_push;

  assign cnt_inc = {evt_drop,
                    evt_fire && (evt_code == CODE_ERR),
                    evt_fire && (evt_code == CODE_S2),
                    evt_fire && (evt_code == CODE_S1)};

  // Two-slot FIFO: head/tail registers; a pop shifts tail into head
  always_comb begin
    buf_head_next = buf_head;
    buf_tail_next = buf_tail;
    buf_cnt_next  = buf_cnt;
    buf_slot      = buf_cnt;
    if (evt_pop) begin
      buf_head_next = buf_tail;
      buf_slot      = buf_cnt - 2'd1;
    end
    if (evt_push) begin
      if (buf_slot == 2'd0) begin
        buf_head_next = evt_code;
      end else begin
        buf_tail_next = evt_code;
      end
    end
    if (evt_push && !evt_pop) begin
      buf_cnt_next = buf_cnt + 2'd1;
    end else if (!evt_push && evt_pop) begin
      buf_cnt_next = buf_cnt - 2'd1;
    end
  end

`ifdef STEP_FSM_MON_MISMATCH_EN
  logic       copies_differ;
  logic       mismatch_copy [3];
  logic       mismatch_voted;

  assign copies_differ  = (state_a_i != state_b_i) || (state_b_i != state_c_i);
  assign mismatch_voted = (mismatch_copy[0] & mismatch_copy[1]) |
                          (mismatch_copy[0] & mismatch_copy[2]) |
                          (mismatch_copy[1] & mismatch_copy[2]);
  assign mismatch_o     = mismatch_voted;
`endif

  genvar gi, ki;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_copy
      logic [IO_SIZE_G-1:0] prev_reg;
      logic [CNT_W_G-1:0]   cnt_reg [N_CNT];
      logic [1:0]           buf_cnt_reg;
      logic [1:0]           buf_head_reg;
      logic [1:0]           buf_tail_reg;

      // Every copy rebuilds its next value from the voted value
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          prev_reg     <= RESET_STATE_G;
          buf_cnt_reg  <= 2'd0;
          buf_head_reg <= 2'd0;
          buf_tail_reg <= 2'd0;
          for (int k = 0; k < N_CNT; k++) begin
            cnt_reg[k] <= '0;
          end
        end else begin
          prev_reg     <= voted_state;
          buf_cnt_reg  <= buf_cnt_next;
          buf_head_reg <= buf_head_next;
          buf_tail_reg <= buf_tail_next;
          for (int k = 0; k < N_CNT; k++) begin
            if (clear_i) begin
              cnt_reg[k] <= '0;
            end else if (cnt_inc[k] && (cnt_voted[k] != CNT_MAX)) begin
              cnt_reg[k] <= cnt_voted[k] + 1'b1;
            end else begin
              cnt_reg[k] <= cnt_voted[k];
            end
          end
        end
      end

      assign prev_copy[gi]     = prev_reg;
      assign buf_cnt_copy[gi]  = buf_cnt_reg;
      assign buf_head_copy[gi] = buf_head_reg;
      assign buf_tail_copy[gi] = buf_tail_reg;

      for (ki = 0; ki < N_CNT; ki++) begin : g_cnt_out
        assign cnt_copy[gi][ki] = cnt_reg[ki];
      end

`ifdef STEP_FSM_MON_MISMATCH_EN
      logic mismatch_reg;

      // Clear wins over a disagreement seen in the same cycle
      always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
          mismatch_reg <= 1'b0;
        end else begin
          mismatch_reg <= mismatch_voted | copies_differ;
        end
      end

      assign mismatch_copy[gi] = mismatch_reg;
`endif
    end

    for (ki = 0; ki < N_CNT; ki++) begin : g_cnt_vote
      assign cnt_voted[ki] = (cnt_copy[0][ki] & cnt_copy[1][ki]) |
                             (cnt_copy[0][ki] & cnt_copy[2][ki]) |
                             (cnt_copy[1][ki] & cnt_copy[2][ki]);
    end
  endgenerate

  assign s1_cnt_o   = cnt_voted[0];
  assign s2_cnt_o   = cnt_voted[1];
  assign err_cnt_o  = cnt_voted[2];
  assign drop_cnt_o = cnt_voted[3];

endmodule

// File: tb/tb_step_fsm_monitor_tmr.sv
// ---------------------------------------------------------------------------
// tb_step_fsm_monitor_tmr
//
// Self-checking bench for step_fsm_monitor_tmr with 4-bit counters. It starts
// with directed sequences from the test plan and then runs random stimulus.
// Every cycle, all outputs are compared against a behavioural model that
// keeps the event buffer as a queue and the counters as plain integers.
// ---------------------------------------------------------------------------
module tb_step_fsm_monitor_tmr;

  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [2:0]    state_a_i, state_b_i, state_c_i;
  logic          clear_i;
  logic [CW-1:0] s1_cnt_o, s2_cnt_o, err_cnt_o, drop_cnt_o;
  logic          evt_valid_o;
  logic [1:0]    evt_code_o;
  logic          evt_ready_i;
`ifdef STEP_FSM_MON_MISMATCH_EN
  logic          mismatch_o;
`endif

  always #5 clk_i = ~clk_i;

  step_fsm_monitor_tmr #(.CNT_W_G(CW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .state_a_i   (state_a_i),
    .state_b_i   (state_b_i),
    .state_c_i   (state_c_i),
    .clear_i     (clear_i),
    .s1_cnt_o    (s1_cnt_o),
    .s2_cnt_o    (s2_cnt_o),
    .err_cnt_o   (err_cnt_o),
    .drop_cnt_o  (drop_cnt_o),
    .evt_valid_o (evt_valid_o),
    .evt_code_o  (evt_code_o),
    .evt_ready_i (evt_ready_i)
`ifdef STEP_FSM_MON_MISMATCH_EN
    ,
    .mismatch_o  (mismatch_o)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_s1, m_s2, m_err, m_drop;
  int         m_prev;
  bit         m_mismatch;
  logic [1:0] m_q[$];

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int vote_bits(input int a, input int b, input int c);
    int v = 0;
    for (int i = 0; i < 3; i++) begin
      if (((a >> i) & 1) + ((b >> i) & 1) + ((c >> i) & 1) >= 2) v += (1 << i);
    end
    return v;
  endfunction

  function automatic int sat_inc(input int v);
    return (v < MAX) ? v + 1 : v;
  endfunction

  // One clock edge of the model, with the inputs applied at that edge
  task automatic model_edge();
    int v;
    int code;
    if (rst_i) begin
      m_s1 = 0; m_s2 = 0; m_err = 0; m_drop = 0;
      m_prev = 0;
      m_mismatch = 0;
      m_q.delete();
      return;
    end
    v    = vote_bits(state_a_i, state_b_i, state_c_i);
    code = 0;
    if (v != m_prev) begin
      if (v == 3) code = 1;
      else if (v == 6) code = 2;
      else if (v == 7) code = 3;
    end
    if (m_q.size() > 0 && evt_ready_i) begin
      $display("pop  code=%b t=%0t", m_q[0], $time);
      void'(m_q.pop_front());
    end
    if (code != 0) begin
      if (m_q.size() < 2) begin
        m_q.push_back(2'(code));
      end else begin
        $display("drop code=%b t=%0t", 2'(code), $time);
      end
    end
    if (clear_i) begin
      m_s1 = 0; m_s2 = 0; m_err = 0; m_drop = 0;
    end else if (code != 0) begin
      if (code == 1) m_s1 = sat_inc(m_s1);
      if (code == 2) m_s2 = sat_inc(m_s2);
      if (code == 3) m_err = sat_inc(m_err);
      if (m_q.size() == 2 && !(m_q[1] == 2'(code))) begin
        // unreachable ordering case is covered by the drop test below
      end
    end
    if (!clear_i && code != 0 && m_q.size() == 2) begin
      // drop counting handled separately so clear priority stays explicit
    end
    if (clear_i || rst_i) m_mismatch = 0;
    else if (state_a_i != state_b_i || state_b_i != state_c_i) m_mismatch = 1;
    m_prev = v;
  endtask

  int m_size_before;

  task automatic compare_all();
    check_val("s1_cnt", int'(s1_cnt_o), m_s1);
    check_val("s2_cnt", int'(s2_cnt_o), m_s2);
    check_val("err_cnt", int'(err_cnt_o), m_err);
    check_val("drop_cnt", int'(drop_cnt_o), m_drop);
    check_val("evt_valid", int'(evt_valid_o), (m_q.size() > 0) ? 1 : 0);
    check_val("evt_code", int'(evt_code_o), (m_q.size() > 0) ? int'(m_q[0]) : 0);
`ifdef STEP_FSM_MON_MISMATCH_EN
    check_val("mismatch", int'(mismatch_o), int'(m_mismatch));
`endif
  endtask

  // Apply one cycle of inputs, advance model at the edge, compare mid-cycle
  task automatic cycle(input int a, input int b, input int c,
                       input bit clr, input bit rdy, input bit rst);
    int  full_before;
    int  v;
    bit  drop_now;
    state_a_i   = 3'(a);
    state_b_i   = 3'(b);
    state_c_i   = 3'(c);
    clear_i     = clr;
    evt_ready_i = rdy;
    rst_i       = rst;
    // Drop decision taken from the queue as it stands before this edge
    full_before = m_q.size();
    v = vote_bits(a, b, c);
    drop_now = !rst && (v != m_prev) && (v == 3 || v == 6 || v == 7) &&
               (full_before == 2) && !rdy;
    @(posedge clk_i);
    model_edge();
    if (!rst && !clr && drop_now) m_drop = sat_inc(m_drop);
    @(negedge clk_i);
    compare_all();
  endtask

  task automatic same(input int s, input bit clr, input bit rdy);
    cycle(s, s, s, clr, rdy, 1'b0);
  endtask

  initial begin
    state_a_i = '0; state_b_i = '0; state_c_i = '0;
    clear_i = 0; evt_ready_i = 0; rst_i = 1;
    m_s1 = 0; m_s2 = 0; m_err = 0; m_drop = 0; m_prev = 0; m_mismatch = 0;

    // Reset state
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);

    // S1 walk with ready high
    same(0, 0, 1); same(1, 0, 1); same(2, 0, 1); same(3, 0, 1); same(0, 0, 1);
    same(0, 0, 1);
    check_val("dir_s1_one", int'(s1_cnt_o), 1);

    // Fill buffer with ready low: S1, S2, ERROR -> ERROR dropped
    same(3, 0, 0); same(0, 0, 0); same(6, 0, 0); same(0, 0, 0); same(7, 0, 0);
    check_val("dir_drop_one", int'(drop_cnt_o), 1);
    check_val("dir_head_s1", int'(evt_code_o), 1);
    same(0, 0, 1); same(0, 0, 1); same(0, 0, 1);
    check_val("dir_drained", int'(evt_valid_o), 0);

    // Single corrupted copy: voted S1_C, no ERROR event
    cycle(3, 7, 3, 0, 1, 0);
    same(3, 0, 1); same(3, 0, 1); same(0, 0, 1);

    // Saturate the error counter
    for (int i = 0; i < MAX + 2; i++) begin
      same(7, 0, 1);
      same(0, 0, 1);
    end
    check_val("dir_err_sat", int'(err_cnt_o), MAX);

    // Clear in the same cycle as an S2 entry
    same(6, 1, 0);
    check_val("dir_clr_s2cnt", int'(s2_cnt_o), 0);
    check_val("dir_clr_code", int'(evt_code_o), 2);

    // Full buffer, pop plus new event in the same cycle
    same(0, 0, 0); same(3, 0, 0); same(0, 0, 0); same(7, 0, 1);
    same(0, 0, 1); same(0, 0, 1); same(0, 0, 1);

    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      int s, a, b, c;
      bit clr, rdy, rst;
      s = $urandom_range(0, 7);
      if ($urandom_range(0, 2) == 0) s = 0;
      a = s; b = s; c = s;
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 2))
          0: a = $urandom_range(0, 7);
          1: b = $urandom_range(0, 7);
          default: c = $urandom_range(0, 7);
        endcase
      end
      clr = ($urandom_range(0, 59) == 0);
      rdy = ((n / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 399) == 0);
      cycle(a, b, c, clr, rdy, rst);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

endmodule
